// File: rtl/float_pkg.sv
// Shared types and default widths for the FP normalization stage.
package float_pkg;
  localparam int N_MANT = 24;
  localparam int N_EXP  = 8;
  localparam logic [N_EXP-1:0] EXP_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/float_normalize.sv
// Normalization stage ahead of FP rounding: right shift by one at capture,
// left shift one bit per cycle until the hidden bit is set or the exponent hits 0.
module float_normalize
  import float_pkg::*;
#(
  parameter int N  = N_MANT,
  parameter int EW = N_EXP
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [N+2:0]  rawMant,
  input  logic [EW-1:0] rawExp,
  input  logic          inValid,
  output logic          inReady,
  output logic [N-1:0]  normMant,
  output logic [EW-1:0] normExp,
  output logic          R,
  output logic          S,
  output logic          oflow,
  output logic          uflow,
  output logic          outValid,
  input  logic          outReady,
  output state_t        fsm_state
);
  // Handshake: a transfer happens on an edge where valid and ready are both 1;
  // valid holds its data unchanged until that edge, and never waits on ready.

  localparam logic [EW-1:0] E_MAX = '1;
  localparam logic [EW-1:0] E_SAT = E_MAX - 1'b1;

  state_t        state, state_n;
  logic [N-1:0]  m, m_n;
  logic          r_bit, r_n, s_bit, s_n;
  logic [EW-1:0] e, e_n;
  logic          of_q, of_n, uf_q, uf_n;

  logic          raw_carry;
  logic [N-1:0]  raw_m;
  logic          raw_r, raw_s;
  logic [N-1:0]  m_sh;
  logic [EW-1:0] e_dec;

  assign raw_carry = rawMant[N+2];
  assign raw_m     = rawMant[N+1:2];
  assign raw_r     = rawMant[1];
  assign raw_s     = rawMant[0];
  assign m_sh      = {m[N-2:0], r_bit};
  assign e_dec     = e - 1'b1;

  always_comb begin
    state_n = state;
    m_n     = m;
    r_n     = r_bit;
    s_n     = s_bit;
    e_n     = e;
    of_n    = of_q;
    uf_n    = uf_q;
    case (state)
      IDLE: begin
        if (inValid) begin
          m_n     = raw_m;
          r_n     = raw_r;
          s_n     = raw_s;
          e_n     = rawExp;
          of_n    = 1'b0;
          uf_n    = 1'b0;
          state_n = DONE;
          if (!raw_carry && raw_m == '0 && !raw_r && !raw_s) begin
            e_n = '0;
          end else if (raw_carry) begin
            // Exponent would reach all-ones: saturate and flush the mantissa.
            if (rawExp >= E_SAT) begin
              m_n  = '0;
              r_n  = 1'b0;
              s_n  = 1'b0;
              e_n  = E_MAX;
              of_n = 1'b1;
            end else begin
              m_n = {1'b1, raw_m[N-1:1]};
              r_n = raw_m[0];
              s_n = raw_r | raw_s;
              e_n = rawExp + 1'b1;
            end
          end else if (raw_m[N-1]) begin
            state_n = DONE;
          end else if (rawExp == '0) begin
            uf_n = 1'b1;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      SHIFT: begin
        m_n = m_sh;
        r_n = 1'b0;
        e_n = e_dec;
        if (m_sh[N-1] || e_dec == '0) begin
          state_n = DONE;
          uf_n    = !m_sh[N-1];
        end
      end
      DONE: begin
        if (outReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      m     <= '0;
      r_bit <= 1'b0;
      s_bit <= 1'b0;
      e     <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      state <= state_n;
      m     <= m_n;
      r_bit <= r_n;
      s_bit <= s_n;
      e     <= e_n;
      of_q  <= of_n;
      uf_q  <= uf_n;
    end
  end

  assign inReady   = (state == IDLE) && !Reset;
  assign outValid  = (state == DONE);
  assign normMant  = m;
  assign normExp   = e;
  assign R         = r_bit;
  assign S         = s_bit;
  assign oflow     = of_q;
  assign uflow     = uf_q;
  assign fsm_state = state;
endmodule

// File: tb/tb_float_normalize.sv
// Randomized bench for float_normalize, checked against an arithmetic model
// of normalization (leading-zero count, clamped by the exponent).
module tb_float_normalize;
  import float_pkg::*;

  localparam int W = N_MANT + N_EXP + 4;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [N_MANT+2:0]  rawMant;
  logic [N_EXP-1:0]   rawExp;
  logic               inValid;
  logic               inReady;
  logic [N_MANT-1:0]  normMant;
  logic [N_EXP-1:0]   normExp;
  logic               R, S, oflow, uflow, outValid, outReady;
  state_t             fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  int           lat_q[$];

  float_normalize dut (
    .Clock(Clock), .Reset(Reset), .rawMant(rawMant), .rawExp(rawExp),
    .inValid(inValid), .inReady(inReady), .normMant(normMant), .normExp(normExp),
    .R(R), .S(S), .oflow(oflow), .uflow(uflow), .outValid(outValid),
    .outReady(outReady), .fsm_state(fsm_state)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, want);
  endtask

  // Result packed as {mant, exp, R, S, oflow, uflow}; lat = edges from capture to outValid.
  function automatic void model(input logic [N_MANT+2:0] raw, input logic [N_EXP-1:0] ex,
                                output logic [W-1:0] res, output int lat);
    logic              c, r, s;
    logic [N_MANT-1:0] mt;
    logic [49:0]       w;
    int                lz, k;
    c  = raw[N_MANT+2];
    mt = raw[N_MANT+1:2];
    r  = raw[1];
    s  = raw[0];
    lat = 1;
    if (raw == '0) begin
      res = '0;
    end else if (c) begin
      if (ex >= 8'd254) res = {24'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
      else              res = {1'b1, mt[23:1], ex + 8'd1, mt[0], r | s, 2'b00};
    end else if (mt[23]) begin
      res = {mt, ex, r, s, 2'b00};
    end else begin
      lz = 0;
      while (lz < 24 && !mt[23-lz]) lz++;
      if (mt == '0 && !r) lz = 1000;
      k = (lz < int'(ex)) ? lz : int'(ex);
      w = {25'b0, mt, r} << k;
      res = {w[24:1], ex - 8'(k), w[0], s, 1'b0, (lz > k) ? 1'b1 : 1'b0};
      lat = k + 1;
    end
  endfunction

  task automatic send(input logic [N_MANT+2:0] raw, input logic [N_EXP-1:0] ex, input int hold);
    logic [W-1:0] res, want, obs;
    int lat, cyc, guard;
    model(raw, ex, res, lat);
    exp_q.push_back(res);
    lat_q.push_back(lat);
    guard = 0;
    while (!inReady && guard < 50) begin @(posedge Clock); #1; guard++; end
    check("in_ready_idle", inReady, 1);
    rawMant = raw; rawExp = ex; inValid = 1'b1;
    @(posedge Clock); #1;
    inValid = 1'b0; rawMant = 27'($urandom); rawExp = 8'($urandom);
    cyc = 1;
    while (!outValid && cyc < 40) begin
      check("busy_in_ready", inReady, 0);
      @(posedge Clock); #1;
      cyc++;
    end
    want = exp_q.pop_front();
    check("latency", cyc, lat_q.pop_front());
    check("out_valid", outValid, 1);
    check("norm_mant", normMant, want[W-1 -: N_MANT]);
    check("norm_exp", normExp, want[11:4]);
    check("r_bit", R, want[3]);
    check("s_bit", S, want[2]);
    check("oflow", oflow, want[1]);
    check("uflow", uflow, want[0]);
    obs = {normMant, normExp, R, S, oflow, uflow};
    repeat (hold) begin
      @(posedge Clock); #1;
      check("hold_valid", outValid, 1);
      check("hold_stable", {normMant, normExp, R, S, oflow, uflow}, obs);
      check("hold_in_ready", inReady, 0);
    end
    outReady = 1'b1;
    @(posedge Clock); #1;
    outReady = 1'b0;
    check("drop_valid", outValid, 0);
    check("idle_ready", inReady, 1);
  endtask

  initial begin
    logic [N_MANT-1:0] mt;
    logic [N_EXP-1:0]  ex;
    int cat, lz;
    Reset = 1'b1; rawMant = '0; rawExp = '0; inValid = 1'b0; outReady = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_state", fsm_state, IDLE);
    check("rst_mant", normMant, 0);
    check("rst_exp", normExp, 0);
    check("rst_flags", {R, S, oflow, uflow, outValid}, 0);
    check("rst_in_ready", inReady, 0);
    Reset = 1'b0;
    #1;
    check("post_rst_ready", inReady, 1);

    send({1'b1, 24'h000001, 1'b1, 1'b0}, 8'h80, 0);
    send({1'b0, 24'hC00000, 1'b0, 1'b1}, 8'h7F, 0);
    send({1'b0, 24'h100000, 1'b1, 1'b0}, 8'h85, 0);
    send({1'b0, 24'h000010, 1'b0, 1'b0}, 8'h02, 0);
    send(27'h0, 8'h55, 0);
    send({1'b1, 24'hFFFFFF, 1'b1, 1'b1}, 8'hFE, 0);
    send({1'b1, 24'h123456, 1'b0, 1'b1}, 8'hFD, 0);
    send({1'b0, 24'h000001, 1'b0, 1'b0}, 8'h80, 5);
    send({1'b0, 24'h000000, 1'b1, 1'b1}, 8'h40, 0);
    send({1'b0, 24'h400000, 1'b0, 1'b1}, 8'h00, 0);
    send({1'b0, 24'h000000, 1'b0, 1'b1}, 8'h03, 2);

    // Reset during SHIFT drops the operand entirely.
    rawMant = {1'b0, 24'h100000, 1'b1, 1'b0}; rawExp = 8'h85; inValid = 1'b1;
    @(posedge Clock); #1;
    inValid = 1'b0;
    @(posedge Clock); #1;
    check("mid_shift_state", fsm_state, SHIFT);
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("abort_state", fsm_state, IDLE);
    check("abort_outputs", {normMant, normExp, R, S, oflow, uflow, outValid}, 0);
    check("abort_in_ready", inReady, 0);
    Reset = 1'b0;
    #1;
    send({1'b0, 24'h080000, 1'b0, 1'b0}, 8'h10, 1);

    for (int i = 0; i < 150; i++) begin
      cat = $urandom_range(0, 5);
      lz  = $urandom_range(0, 24);
      mt  = 24'($urandom) >> lz;
      if (lz < 24) mt[23-lz] = 1'b1;
      case (cat)
        1:       ex = 8'($urandom_range(0, 4));
        2:       ex = 8'($urandom_range(250, 255));
        default: ex = 8'($urandom_range(0, 255));
      endcase
      if (cat == 5) send(27'h0, ex, $urandom_range(0, 2));
      else send({(cat == 0 || cat == 2) ? 1'b1 : 1'b0, mt, 1'($urandom), 1'($urandom)},
                ex, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
